// File: rtl/prg_cart_loader.sv
// Download loader: steers hps_io ioctl PRG/cartridge bytes onto a req/ack
// configuration write port, tracks loaded cartridge blocks, patches BASIC end pointers.
module prg_cart_loader #(
    parameter int unsigned            ADDR_W     = 16,
    parameter logic [7:0]             PRG_IDX    = 8'd1,
    parameter logic [7:0]             CRT_IDX    = 8'd2,
    parameter logic [4:0]             RAW_IDX    = 5'd3,
    parameter logic [4*ADDR_W-1:0]    SLOT_BASE  = {16'hB000, 16'hA000, 16'h6000, 16'h4000},
    parameter logic [ADDR_W-1:0]      PRG_LIMIT  = 16'hA000,
    parameter logic [ADDR_W-1:0]      CART_LIMIT = 16'hC000,
    parameter int unsigned            BLK_SHIFT  = 13,
    parameter int unsigned            NBLK       = 8,
    parameter int unsigned            PTR_N      = 4,
    parameter logic [PTR_N*8-1:0]     PTR_LIST   = {8'hAE, 8'h31, 8'h2F, 8'h2D}
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dl_addr,
    output logic [7:0]        dl_data,
    output logic              dl_req,
    input  logic              dl_ack,
    output logic [NBLK-1:0]   cart_blk,
    output logic              cart_reset,
    output logic              busy,
    output logic              truncated,
    output logic [ADDR_W-1:0] end_addr
);

    localparam int unsigned PW = (PTR_N > 1) ? $clog2(PTR_N) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRG      = 3'd1,
        CART     = 3'd2,
        PATCH_LO = 3'd3,
        PATCH_HI = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0]     p_q, p_d;
    logic              raw_q, raw_d;
    logic              dl_prev_q;
    logic              dl_req_q, dl_req_d;
    logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
    logic [7:0]        dl_data_q, dl_data_d;
    logic              ioctl_wait_q, ioctl_wait_d;
    logic              cart_reset_q, cart_reset_d;
    logic              busy_q, busy_d;
    logic              truncated_q, truncated_d;
    logic [NBLK-1:0]   cart_blk_q, cart_blk_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;

    logic              dl_rise;
    logic              pend_done;
    logic [ADDR_W-1:0] slot_base;
    logic [7:0]        ptr_cur;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] blk_idx;

    assign dl_rise   = ioctl_download && !dl_prev_q;
    assign pend_done = !dl_req_q || dl_ack;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        p_d          = p_q;
        raw_d        = raw_q;
        dl_req_d     = dl_req_q && !dl_ack;
        dl_addr_d    = dl_addr_q;
        dl_data_d    = dl_data_q;
        cart_reset_d = cart_reset_q;
        truncated_d  = truncated_q;
        cart_blk_d   = cart_blk_q;
        end_addr_d   = end_addr_q;
        wr_addr      = addr_q;
        blk_idx      = '0;
        slot_base    = '0;
        ptr_cur      = '0;

        for (int s = 0; s < 4; s++) begin
            if (ioctl_index[7:6] == 2'(s)) slot_base = SLOT_BASE[s*ADDR_W +: ADDR_W];
        end
        for (int k = 0; k < PTR_N; k++) begin
            if (p_q == PW'(k)) ptr_cur = PTR_LIST[k*8 +: 8];
        end
        limit = (state_q == CART) ? CART_LIMIT : PRG_LIMIT;

        case (state_q)
            IDLE: begin
                if (dl_rise) begin
                    if (ioctl_index == PRG_IDX) begin
                        state_d = PRG;
                        raw_d   = 1'b0;
                        addr_d  = '0;
                    end else if (ioctl_index == CRT_IDX || ioctl_index[4:0] == RAW_IDX) begin
                        state_d      = CART;
                        raw_d        = (ioctl_index != CRT_IDX);
                        addr_d       = '0;
                        cart_reset_d = 1'b1;
                    end
                end
            end
            PRG, CART: begin
                if (ioctl_download && ioctl_wr) begin
                    // A strobe while the previous write is still pending is an overrun
                    if (dl_req_q) begin
                        truncated_d = 1'b1;
                    end else if (!raw_q && ioctl_addr == 25'd0) begin
                        addr_d[7:0] = ioctl_dout;
                    end else if (!raw_q && ioctl_addr == 25'd1) begin
                        addr_d[15:8] = ioctl_dout;
                    end else begin
                        wr_addr = (raw_q && ioctl_addr == 25'd0) ? slot_base : addr_q;
                        if (wr_addr >= limit) begin
                            truncated_d = 1'b1;
                            addr_d      = wr_addr;
                        end else begin
                            dl_req_d  = 1'b1;
                            dl_addr_d = wr_addr;
                            dl_data_d = ioctl_dout;
                            addr_d    = wr_addr + ADDR_W'(1);
                            if (state_q == CART) begin
                                blk_idx = wr_addr >> BLK_SHIFT;
                                for (int k = 0; k < NBLK; k++) begin
                                    if (blk_idx == ADDR_W'(k)) cart_blk_d[k] = 1'b1;
                                end
                            end
                        end
                    end
                end else if (!ioctl_download && pend_done) begin
                    if (state_q == PRG) begin
                        state_d    = PATCH_LO;
                        p_d        = '0;
                        end_addr_d = addr_q;
                    end else begin
                        state_d      = IDLE;
                        cart_reset_d = 1'b0;
                    end
                end
            end
            PATCH_LO: begin
                if (!dl_req_q) begin
                    dl_req_d  = 1'b1;
                    dl_addr_d = ADDR_W'(ptr_cur);
                    dl_data_d = end_addr_q[7:0];
                end else if (dl_ack) begin
                    state_d = PATCH_HI;
                end
            end
            PATCH_HI: begin
                if (!dl_req_q) begin
                    dl_req_d  = 1'b1;
                    dl_addr_d = ADDR_W'(ptr_cur) + ADDR_W'(1);
                    dl_data_d = end_addr_q[15:8];
                end else if (dl_ack) begin
                    if (p_q == PW'(PTR_N - 1)) begin
                        state_d = IDLE;
                    end else begin
                        p_d     = PW'(p_q + 1'b1);
                        state_d = PATCH_LO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // System clear beats a simultaneous block set but leaves the FSM alone
        if (clr) begin
            cart_blk_d   = '0;
            cart_reset_d = 1'b0;
            truncated_d  = 1'b0;
        end

        ioctl_wait_d = dl_req_d || state_d == PATCH_LO || state_d == PATCH_HI;
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            p_q          <= '0;
            raw_q        <= 1'b0;
            dl_prev_q    <= 1'b0;
            dl_req_q     <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            ioctl_wait_q <= 1'b0;
            cart_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            truncated_q  <= 1'b0;
            cart_blk_q   <= '0;
            end_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            p_q          <= p_d;
            raw_q        <= raw_d;
            dl_prev_q    <= ioctl_download;
            dl_req_q     <= dl_req_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            ioctl_wait_q <= ioctl_wait_d;
            cart_reset_q <= cart_reset_d;
            busy_q       <= busy_d;
            truncated_q  <= truncated_d;
            cart_blk_q   <= cart_blk_d;
            end_addr_q   <= end_addr_d;
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;
    assign dl_req     = dl_req_q;
    assign cart_blk   = cart_blk_q;
    assign cart_reset = cart_reset_q;
    assign busy       = busy_q;
    assign truncated  = truncated_q;
    assign end_addr   = end_addr_q;

endmodule
